// File: rtl/vga_pkg.sv
// Timing constants for 800x600@60 Hz VESA (40 MHz pixel clock) and shared widths.
package vga_pkg;

    localparam int unsigned VGA_CNT_W   = 11;
    localparam int unsigned RGB_W       = 12;
    localparam int unsigned FRAME_CNT_W = 16;

    localparam int unsigned H_TOTAL      = 1056;
    localparam int unsigned H_VISIBLE    = 800;
    localparam int unsigned H_SYNC_START = 840;
    localparam int unsigned H_SYNC_LEN   = 128;

    localparam int unsigned V_TOTAL      = 628;
    localparam int unsigned V_VISIBLE    = 600;
    localparam int unsigned V_SYNC_START = 601;
    localparam int unsigned V_SYNC_LEN   = 4;

endpackage

// File: rtl/vga_if.sv
// VGA stream bundle passed between drawing stages; all fields travel together.
interface vga_if;
    import vga_pkg::*;

    logic [VGA_CNT_W-1:0] hcount;
    logic [VGA_CNT_W-1:0] vcount;
    logic                 hsync;
    logic                 vsync;
    logic                 hblnk;
    logic                 vblnk;
    logic [RGB_W-1:0]     rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_axis_cnt.sv
// One timing axis: wrapping counter with blank/sync flags and a last-position flag.
// Flags are derived from the next count so they line up with the registered count.
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL       = H_TOTAL,
    parameter int unsigned BLANK_START = H_VISIBLE,
    parameter int unsigned SYNC_START  = H_SYNC_START,
    parameter int unsigned SYNC_LEN    = H_SYNC_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic [VGA_CNT_W-1:0] cnt,
    output logic                 blnk,
    output logic                 sync,
    output logic                 wrap
);

    localparam int unsigned W = VGA_CNT_W;

    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] BLNK_BEG = W'(BLANK_START);
    localparam logic [W-1:0] SYNC_BEG = W'(SYNC_START);
    localparam logic [W-1:0] SYNC_END = W'(SYNC_START + SYNC_LEN);

    logic [W-1:0] cnt_nxt;

    // Next count: advance when enabled, wrap after the last position.
    always_comb begin
        cnt_nxt = cnt;
        if (en) begin
            cnt_nxt = (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    // Count and flags share one register stage; wrap marks the last position.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            blnk <= 1'b0;
            sync <= 1'b0;
            wrap <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            blnk <= (cnt_nxt >= BLNK_BEG);
            sync <= (cnt_nxt >= SYNC_BEG) && (cnt_nxt < SYNC_END);
            wrap <= (cnt_nxt == LAST);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Source of the VGA stream: H/V timing, per-frame tick and completed-frame counter.
module vga_timing_gen #(
    parameter int unsigned H_TOTAL      = vga_pkg::H_TOTAL,
    parameter int unsigned H_VISIBLE    = vga_pkg::H_VISIBLE,
    parameter int unsigned H_SYNC_START = vga_pkg::H_SYNC_START,
    parameter int unsigned H_SYNC_LEN   = vga_pkg::H_SYNC_LEN,
    parameter int unsigned V_TOTAL      = vga_pkg::V_TOTAL,
    parameter int unsigned V_VISIBLE    = vga_pkg::V_VISIBLE,
    parameter int unsigned V_SYNC_START = vga_pkg::V_SYNC_START,
    parameter int unsigned V_SYNC_LEN   = vga_pkg::V_SYNC_LEN
) (
    input  logic                             clk,
    input  logic                             rst,
    vga_if.out                               vga_out,
    output logic                             frame_tick,
    output logic [vga_pkg::FRAME_CNT_W-1:0]  frame_cnt
);

    localparam int unsigned W  = vga_pkg::VGA_CNT_W;
    localparam int unsigned FW = vga_pkg::FRAME_CNT_W;

    // Line before the first blanked line; the tick fires as that line wraps.
    localparam logic [W-1:0] V_TICK_LINE = W'(V_VISIBLE - 1);

    logic [W-1:0] h_cnt;
    logic [W-1:0] v_cnt;
    logic         h_blnk;
    logic         h_sync;
    logic         h_wrap;
    logic         v_blnk;
    logic         v_sync;
    logic         v_wrap;

    vga_axis_cnt #(
        .TOTAL       (H_TOTAL),
        .BLANK_START (H_VISIBLE),
        .SYNC_START  (H_SYNC_START),
        .SYNC_LEN    (H_SYNC_LEN)
    ) u_h (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .cnt  (h_cnt),
        .blnk (h_blnk),
        .sync (h_sync),
        .wrap (h_wrap)
    );

    // Vertical axis steps on the same edge that the horizontal counter wraps.
    vga_axis_cnt #(
        .TOTAL       (V_TOTAL),
        .BLANK_START (V_VISIBLE),
        .SYNC_START  (V_SYNC_START),
        .SYNC_LEN    (V_SYNC_LEN)
    ) u_v (
        .clk  (clk),
        .rst  (rst),
        .en   (h_wrap),
        .cnt  (v_cnt),
        .blnk (v_blnk),
        .sync (v_sync),
        .wrap (v_wrap)
    );

    assign vga_out.hcount = h_cnt;
    assign vga_out.vcount = v_cnt;
    assign vga_out.hsync  = h_sync;
    assign vga_out.vsync  = v_sync;
    assign vga_out.hblnk  = h_blnk;
    assign vga_out.vblnk  = v_blnk;
    assign vga_out.rgb    = '0;

    // Tick lands with (0, V_VISIBLE); frame count bumps as (last, last) wraps to (0, 0).
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_tick <= h_wrap && (v_cnt == V_TICK_LINE);
            if (h_wrap && v_wrap) begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

endmodule
